// File: rtl/quantoniumos_unified_core.sv
// Multi-mode accelerator: 16-point sign-matrix transform, LFSR-weighted SIS hash,
// 64-bit Feistel cipher and a chained pipeline, behind a start/done handshake.
module quantoniumos_unified_core #(
  parameter int unsigned RFT_SIZE       = 64,
  parameter int unsigned SIS_N          = 512,
  parameter int unsigned FEISTEL_ROUNDS = 48
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   mode,
  input  logic [255:0] master_key,
  input  logic [127:0] data_in,
  output logic [255:0] data_out,
  output logic         done,
  output logic [31:0]  rft_energy,
  output logic [15:0]  sis_collision_resistance,
  output logic [5:0]   feistel_round_count,
  output logic [31:0]  pipeline_throughput
);

  localparam int unsigned CNT_W    = 14;
  localparam int unsigned ROUND_W  = 6;
  localparam int unsigned HALF_W   = 64;
  localparam int unsigned BIN_W    = 16;
  localparam logic [CNT_W-1:0] RFT_LAST   = CNT_W'(4 * RFT_SIZE - 1);
  localparam logic [CNT_W-1:0] FEIST_LAST = CNT_W'(FEISTEL_ROUNDS - 1);
  localparam logic [CNT_W-1:0] SIS_LAST   = CNT_W'(16 * SIS_N - 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [2:0] M_RFT   = 3'd0;
  localparam logic [2:0] M_SIS   = 3'd1;
  localparam logic [2:0] M_FEIST = 3'd2;
  localparam logic [2:0] M_PIPE  = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RFT,
    S_FEIST,
    S_SIS,
    S_FIN
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_cyc;
  logic [2:0]          r_mode;
  logic [127:0]        r_din;
  logic [255:0]        r_key;
  logic [BIN_W-1:0]    r_acc;
  logic [255:0]        r_rft;
  logic [31:0]         r_energy;
  logic [HALF_W-1:0]   r_l;
  logic [HALF_W-1:0]   r_r;
  logic [ROUND_W-1:0]  r_rounds;
  logic [15:0]         r_a;
  logic [255:0]        r_h;

  logic                w_accept;
  logic                w_chain;

  // Sign-matrix MAC: k = bin (outer), n = sample (inner)
  logic [3:0]          w_k;
  logic [3:0]          w_n;
  logic [7:0]          w_x;
  logic                w_neg;
  logic [BIN_W-1:0]    w_acc_base;
  logic [BIN_W-1:0]    w_acc_nxt;
  logic                w_bin_done;
  logic [31:0]         w_acc_sx;
  logic [31:0]         w_sq;
  logic [255:0]        w_rft_final;
  logic [127:0]        w_fold;

  logic [ROUND_W-1:0]  w_round;
  logic [HALF_W-1:0]   w_rk;
  logic [HALF_W-1:0]   w_t;
  logic [HALF_W-1:0]   w_f;
  logic [HALF_W-1:0]   w_l_nxt;
  logic [HALF_W-1:0]   w_r_nxt;

  logic [3:0]          w_j;
  logic [127:0]        w_sis_in;
  logic                w_s;
  logic [15:0]         w_a_nxt;
  logic [15:0]         w_h_sel;

  function automatic logic [15:0] popcount256(input logic [255:0] v);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < 256; i++) begin
      c = c + 16'(v[i]);
    end
    return c;
  endfunction

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_chain  = (r_mode == M_PIPE);

  assign w_k        = r_cnt[7:4];
  assign w_n        = r_cnt[3:0];
  assign w_x        = r_din[{w_n, 3'b000} +: 8];
  assign w_neg      = ^(w_n & w_k);
  assign w_acc_base = (w_n == 4'd0) ? '0 : r_acc;
  assign w_acc_nxt  = w_neg ? (w_acc_base - {8'h00, w_x}) : (w_acc_base + {8'h00, w_x});
  assign w_bin_done = (w_n == 4'hF);
  assign w_acc_sx   = {{16{w_acc_nxt[15]}}, w_acc_nxt};
  assign w_sq       = w_acc_sx * w_acc_sx;

  // The last bin lands on the same edge the pipeline hands off to the cipher
  always_comb begin
    w_rft_final          = r_rft;
    w_rft_final[255:240] = w_acc_nxt;
  end
  assign w_fold = w_rft_final[255:128] ^ w_rft_final[127:0];

  assign w_round = r_cnt[ROUND_W-1:0];
  assign w_rk    = r_key[{w_round[1:0], 6'b000000} +: 64] ^ {58'h0, w_round};
  assign w_t     = r_r + w_rk;
  assign w_f     = {w_t[50:0], w_t[63:51]} ^ r_r;
  assign w_l_nxt = r_r;
  assign w_r_nxt = r_l ^ w_f;

  // In the pipeline the hash consumes the cipher output still held in L/R
  assign w_j      = r_cnt[12:9];
  assign w_sis_in = w_chain ? {r_l, r_r} : r_din;
  assign w_s      = w_sis_in[r_cnt[6:0]] ^ r_key[r_cnt[7:0]];
  assign w_a_nxt  = (r_a >> 1) ^ (r_a[0] ? LFSR_TAPS : 16'h0000);
  assign w_h_sel  = r_h[{w_j, 4'b0000} +: 16];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          case (mode)
            M_RFT, M_PIPE: w_state_nxt = S_RFT;
            M_SIS:         w_state_nxt = S_SIS;
            M_FEIST:       w_state_nxt = S_FEIST;
            default:       w_state_nxt = S_FIN;
          endcase
        end
      end
      S_RFT: begin
        if (r_cnt == RFT_LAST) w_state_nxt = w_chain ? S_FEIST : S_FIN;
      end
      S_FEIST: begin
        if (r_cnt == FEIST_LAST) w_state_nxt = w_chain ? S_SIS : S_FIN;
      end
      S_SIS: begin
        if (r_cnt == SIS_LAST) w_state_nxt = S_FIN;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Step counter restarts on every state change
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (r_state != S_IDLE) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc                    <= '0;
      r_mode                   <= '0;
      r_din                    <= '0;
      r_key                    <= '0;
      r_acc                    <= '0;
      r_rft                    <= '0;
      r_energy                 <= '0;
      r_l                      <= '0;
      r_r                      <= '0;
      r_rounds                 <= '0;
      r_a                      <= '0;
      r_h                      <= '0;
      data_out                 <= '0;
      done                     <= 1'b0;
      rft_energy               <= '0;
      sis_collision_resistance <= '0;
      feistel_round_count      <= '0;
      pipeline_throughput      <= '0;
    end else begin
      if (w_accept) begin
        r_mode   <= mode;
        r_din    <= data_in;
        r_key    <= master_key;
        done     <= 1'b0;
        r_cyc    <= 32'd1;
        r_energy <= '0;
        r_rounds <= '0;
        if (mode == M_FEIST) begin
          r_l <= data_in[127:64];
          r_r <= data_in[63:0];
        end
      end else if (r_state != S_IDLE) begin
        r_cyc <= r_cyc + 32'd1;
      end

      if ((w_state_nxt == S_SIS) && (r_state != S_SIS)) begin
        r_a <= LFSR_SEED;
        r_h <= '0;
      end

      case (r_state)
        S_RFT: begin
          r_acc <= w_acc_nxt;
          if (w_bin_done) begin
            r_rft[{w_k, 4'b0000} +: 16] <= w_acc_nxt;
            r_energy <= r_energy + w_sq;
          end
          if (w_state_nxt == S_FEIST) begin
            r_l <= w_fold[127:64];
            r_r <= w_fold[63:0];
          end
        end
        S_FEIST: begin
          r_l      <= w_l_nxt;
          r_r      <= w_r_nxt;
          r_rounds <= r_rounds + ROUND_W'(1);
        end
        S_SIS: begin
          if (w_s) r_h[{w_j, 4'b0000} +: 16] <= w_h_sel + r_a;
          r_a <= w_a_nxt;
        end
        S_FIN: begin
          done                <= 1'b1;
          pipeline_throughput <= r_cyc;
          case (r_mode)
            M_RFT: begin
              data_out   <= r_rft;
              rft_energy <= r_energy;
            end
            M_SIS: begin
              data_out                 <= r_h;
              sis_collision_resistance <= popcount256(r_h);
            end
            M_FEIST: begin
              data_out            <= {128'h0, r_l, r_r};
              feistel_round_count <= r_rounds;
            end
            M_PIPE: begin
              data_out                 <= r_h;
              rft_energy               <= r_energy;
              feistel_round_count      <= r_rounds;
              sis_collision_resistance <= popcount256(r_h);
            end
            default: data_out <= '0;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quantoniumos_unified_core.sv
// Directed scoreboard bench for quantoniumos_unified_core with behavioural models.
module tb_quantoniumos_unified_core;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   mode;
  logic [255:0] master_key;
  logic [127:0] data_in;
  logic [255:0] data_out;
  logic         done;
  logic [31:0]  rft_energy;
  logic [15:0]  sis_collision_resistance;
  logic [5:0]   feistel_round_count;
  logic [31:0]  pipeline_throughput;

  always #5 clk = ~clk;

  quantoniumos_unified_core dut (
    .clk                      (clk),
    .reset                    (reset),
    .start                    (start),
    .mode                     (mode),
    .master_key               (master_key),
    .data_in                  (data_in),
    .data_out                 (data_out),
    .done                     (done),
    .rft_energy               (rft_energy),
    .sis_collision_resistance (sis_collision_resistance),
    .feistel_round_count      (feistel_round_count),
    .pipeline_throughput      (pipeline_throughput)
  );

  typedef struct {
    logic [255:0] data;
    logic [31:0]  e;
    logic [15:0]  sis;
    logic [5:0]   fr;
    logic [31:0]  thr;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_e;
  logic [15:0] m_sis;
  logic [5:0]  m_fr;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rft_vec(input logic [127:0] d);
    logic [255:0] v;
    int s;
    int x;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      s = 0;
      for (int n = 0; n < 16; n++) begin
        x = int'(d[8*n +: 8]);
        if (($countones(n & k) % 2) == 0) s += x;
        else s -= x;
      end
      v[16*k +: 16] = 16'(s);
    end
    return v;
  endfunction

  function automatic logic [31:0] rft_en(input logic [127:0] d);
    int s;
    int e;
    e = 0;
    for (int k = 0; k < 16; k++) begin
      s = 0;
      for (int n = 0; n < 16; n++) begin
        if (($countones(n & k) % 2) == 0) s += int'(d[8*n +: 8]);
        else s -= int'(d[8*n +: 8]);
      end
      e += s * s;
    end
    return 32'(e);
  endfunction

  function automatic logic [127:0] feistel_model(input logic [127:0] d, input logic [255:0] k);
    logic [63:0] l, r, kk, t, f, nr;
    l = d[127:64];
    r = d[63:0];
    for (int i = 0; i < 48; i++) begin
      kk = k[64*(i%4) +: 64] ^ 64'(i);
      t  = r + kk;
      f  = ((t << 13) | (t >> 51)) ^ r;
      nr = l ^ f;
      l  = r;
      r  = nr;
    end
    return {l, r};
  endfunction

  function automatic logic [255:0] sis_model(input logic [127:0] d, input logic [255:0] k);
    logic [15:0]  a;
    logic [15:0]  h[16];
    logic [255:0] o;
    a = 16'hACE1;
    for (int j = 0; j < 16; j++) h[j] = 16'h0;
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 512; i++) begin
        if ((d[i%128] ^ k[i%256]) == 1'b1) h[j] = h[j] + a;
        a = {1'b0, a[15:1]} ^ (a[0] ? 16'hB400 : 16'h0000);
      end
    end
    for (int j = 0; j < 16; j++) o[16*j +: 16] = h[j];
    return o;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, ".data_out"}, data_out, 256'(0));
    check({tag, ".done"}, 256'(done), 256'(0));
    check({tag, ".energy"}, 256'(rft_energy), 256'(0));
    check({tag, ".sis"}, 256'(sis_collision_resistance), 256'(0));
    check({tag, ".rounds"}, 256'(feistel_round_count), 256'(0));
    check({tag, ".thr"}, 256'(pipeline_throughput), 256'(0));
  endtask

  task automatic run_op(input logic [2:0] m, input logic [255:0] k, input logic [127:0] d,
                        input bit busy, input string tag);
    exp_t         x;
    exp_t         g;
    logic [255:0] v;
    logic [127:0] c;
    int           n;
    bit           seen;
    case (m)
      3'd0: begin x.data = rft_vec(d); m_e = rft_en(d); x.thr = 32'd257; end
      3'd1: begin
        x.data = sis_model(d, k); m_sis = 16'($countones(x.data)); x.thr = 32'd8193;
      end
      3'd2: begin x.data = {128'h0, feistel_model(d, k)}; m_fr = 6'd48; x.thr = 32'd49; end
      3'd3: begin
        v = rft_vec(d);
        m_e = rft_en(d);
        c = feistel_model(v[255:128] ^ v[127:0], k);
        x.data = sis_model(c, k);
        m_sis = 16'($countones(x.data));
        m_fr = 6'd48;
        x.thr = 32'd8497;
      end
      default: begin x.data = '0; x.thr = 32'd1; end
    endcase
    x.e = m_e;
    x.sis = m_sis;
    x.fr = m_fr;
    sb.push_back(x);

    @(negedge clk);
    mode = m;
    master_key = k;
    data_in = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, ".done_clr"}, 256'(done), 256'(0));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10000) begin
      @(posedge clk);
      #1;
      n++;
      if (busy && n == 4) begin
        start = 1'b1;
        mode = 3'd2;
        data_in = ~d;
        master_key = ~k;
      end
      if (busy && n == 5) start = 1'b0;
      seen = done;
    end
    g = sb.pop_front();
    check({tag, ".latency"}, 256'(n), 256'(g.thr));
    check({tag, ".data_out"}, data_out, g.data);
    check({tag, ".energy"}, 256'(rft_energy), 256'(g.e));
    check({tag, ".sis"}, 256'(sis_collision_resistance), 256'(g.sis));
    check({tag, ".rounds"}, 256'(feistel_round_count), 256'(g.fr));
    check({tag, ".thr"}, 256'(pipeline_throughput), 256'(g.thr));
  endtask

  initial begin
    logic [255:0] key_seq;
    logic [255:0] key_pipe;
    logic [255:0] v;
    key_seq  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    key_pipe = 256'h0badf00d_deadbeef_cafebabe_12345678_0badf00d_feedface_01234567_89abcdef;
    reset = 1'b1;
    start = 1'b0;
    mode = 3'd0;
    master_key = '0;
    data_in = '0;
    m_e = '0;
    m_sis = '0;
    m_fr = '0;

    repeat (5) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Impulse: every bin is +1
    run_op(3'd0, '0, 128'h1, 1'b0, "rft_impulse");
    check("rft_impulse.const", data_out, {16{16'h0001}});
    check("rft_impulse.energy16", 256'(rft_energy), 256'(16));
    repeat (3) @(posedge clk);
    #1;
    check("rft_impulse.done_held", 256'(done), 256'(1));

    run_op(3'd0, '0, 128'h0, 1'b0, "rft_zero");
    run_op(3'd2, key_seq, 128'h00112233445566778899aabbccddeeff, 1'b0, "feistel");
    check("feistel.upper_zero", 256'(data_out[255:128]), 256'(0));

    run_op(3'd1, '0, 128'h0, 1'b0, "sis_zero");
    run_op(3'd1, '0, 128'h112233445566778899aabbccddeeff00, 1'b0, "sis_data");
    run_op(3'd3, key_pipe, 128'ha5a5a5a5_5a5a5a5a_f0f0f0f0_0f0f0f0f, 1'b0, "pipeline");
    run_op(3'd5, key_pipe, 128'hdeadbeef, 1'b0, "reserved");

    // Second start during a run must not disturb it
    v = 256'h0;
    run_op(3'd0, '0, 128'h0102030405060708090a0b0c0d0e0f10, 1'b1, "busy_start");

    // Abort a hash mid-run
    @(negedge clk);
    mode = 3'd1;
    master_key = key_seq;
    data_in = 128'hcafef00d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    m_e = '0;
    m_sis = '0;
    m_fr = '0;
    run_op(3'd1, key_seq, 128'hcafef00d, 1'b0, "after_reset");
    check("after_reset.sb_empty", 256'(sb.size()), v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
